// File: rtl/i2c_ball_pkg.sv
// Shared types and constants for the right-player I2C ball hand-off receiver.
package i2c_ball_pkg;

  localparam logic [7:0] SLAVE_ADDR_DEF = 8'hAA;
  localparam int         NUM_DATA_DEF   = 5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } rx_state_t;

  localparam int IDX_YHI  = 0;
  localparam int IDX_YLO  = 1;
  localparam int IDX_VY   = 2;
  localparam int IDX_GRAV = 3;
  localparam int IDX_COLL = 4;

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA into clk and derives edge and START/STOP strobes.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;

  // Reset to the idle-bus level so release from reset creates no false edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_ball_receiver.sv
// Write-only I2C slave that reassembles the ball hand-off frame for the right player.
//   state    | meaning
//   IDLE     | bus idle, waiting for START
//   ADDR     | shifting in the address byte
//   ADDR_ACK | driving ACK for a matched address
//   DATA     | shifting in a data byte
//   DATA_ACK | driving ACK for an accepted data byte
//   IGNORE   | NACKed transfer, waiting for STOP or START
module i2c_ball_receiver
  import i2c_ball_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR  = SLAVE_ADDR_DEF,
  parameter int         NUM_DATA    = NUM_DATA_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic [1:0] gravity_counter,
  output logic       is_collusion,
  output logic       ball_data_valid,
  output logic       frame_error,
  output logic       busy
);

  localparam int CNT_W = $clog2(NUM_DATA + 1);

  logic             scl_rise;
  logic             scl_fall;
  logic             start_det;
  logic             stop_det;
  logic             sda_s;
  rx_state_t        state;
  logic [7:0]       shift_reg;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic             addr_match;
  logic             overflow;
  logic [7:0]       staging [NUM_DATA];
  logic             unused_bits;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      shift_reg       <= '0;
      bit_cnt         <= '0;
      byte_cnt        <= '0;
      addr_match      <= 1'b0;
      overflow        <= 1'b0;
      sda_oe          <= 1'b0;
      busy            <= 1'b0;
      ball_data_valid <= 1'b0;
      frame_error     <= 1'b0;
      ball_y          <= '0;
      ball_vy         <= '0;
      gravity_counter <= '0;
      is_collusion    <= 1'b0;
      for (int i = 0; i < NUM_DATA; i++) staging[i] <= '0;
    end else begin
      ball_data_valid <= 1'b0;
      frame_error     <= 1'b0;
      if (stop_det && state != IDLE) begin
        if (addr_match && byte_cnt == CNT_W'(NUM_DATA) && !overflow) begin
          ball_y          <= {staging[IDX_YHI][7:6], staging[IDX_YLO]};
          ball_vy         <= staging[IDX_VY];
          gravity_counter <= staging[IDX_GRAV][1:0];
          is_collusion    <= staging[IDX_COLL][0];
          ball_data_valid <= 1'b1;
        end else if (addr_match) begin
          frame_error <= 1'b1;
        end
        state      <= IDLE;
        busy       <= 1'b0;
        sda_oe     <= 1'b0;
        byte_cnt   <= '0;
        bit_cnt    <= '0;
        addr_match <= 1'b0;
        overflow   <= 1'b0;
      end else if (start_det) begin
        // Repeated START aborts whatever was in flight.
        frame_error <= busy;
        state       <= ADDR;
        busy        <= 1'b0;
        sda_oe      <= 1'b0;
        byte_cnt    <= '0;
        bit_cnt     <= '0;
        addr_match  <= 1'b0;
        overflow    <= 1'b0;
        for (int i = 0; i < NUM_DATA; i++) staging[i] <= '0;
      end else begin
        case (state)
          ADDR, DATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift_reg <= {shift_reg[6:0], sda_s};
              bit_cnt   <= bit_cnt + 1'b1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == ADDR) begin
                if (shift_reg == SLAVE_ADDR) begin
                  state      <= ADDR_ACK;
                  sda_oe     <= 1'b1;
                  busy       <= 1'b1;
                  addr_match <= 1'b1;
                end else begin
                  state  <= IGNORE;
                  sda_oe <= 1'b0;
                end
              end else if (byte_cnt < CNT_W'(NUM_DATA)) begin
                staging[byte_cnt] <= shift_reg;
                byte_cnt          <= byte_cnt + 1'b1;
                sda_oe            <= 1'b1;
                state             <= DATA_ACK;
              end else begin
                overflow <= 1'b1;
                sda_oe   <= 1'b0;
                state    <= IGNORE;
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign unused_bits = ^{staging[IDX_YHI][5:0], staging[IDX_GRAV][7:2], staging[IDX_COLL][7:1]};

endmodule

// File: tb/tb_i2c_ball_receiver.sv
// Directed bench: bit-bangs I2C frames into the receiver and checks ACKs, pulses and outputs.
module tb_i2c_ball_receiver;

  localparam int Q = 80;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic [1:0] gravity_counter;
  logic       is_collusion;
  logic       ball_data_valid;
  logic       frame_error;
  logic       busy;

  int  n_vec = 0;
  int  n_bad = 0;
  int  valid_cnt = 0;
  int  err_cnt = 0;
  int  oe_cnt = 0;
  time t_valid = 0;
  time t_rise = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_ball_receiver dut (
    .clk             (clk),
    .reset           (reset),
    .scl             (scl),
    .sda_in          (sda_line),
    .sda_oe          (sda_oe),
    .ball_y          (ball_y),
    .ball_vy         (ball_vy),
    .gravity_counter (gravity_counter),
    .is_collusion    (is_collusion),
    .ball_data_valid (ball_data_valid),
    .frame_error     (frame_error),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ball_data_valid) begin
      valid_cnt++;
      t_valid = $time;
    end
    if (frame_error) err_cnt++;
    if (sda_oe) oe_cnt++;
  end

  typedef struct {
    logic [55:0] bytes;
    int          nb;
    logic [6:0]  ack;
    int          e_valid;
    int          e_err;
    logic [9:0]  y;
    logic [7:0]  vy;
    logic [1:0]  g;
    logic        c;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl   = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl   = 1'b1; #Q;
    sda_m = 1'b1;
    t_rise = $time;
    #(4*Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) begin
      sda_m = b[k]; #Q;
      scl = 1'b1; #(2*Q);
      scl = 1'b0; #Q;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    ack = sda_oe; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic send_frame(input logic [55:0] bytes, input int nb, output logic [6:0] acks);
    logic a;
    acks = '0;
    i2c_start();
    for (int i = 0; i < nb; i++) begin
      send_byte(bytes[55-8*i -: 8], a);
      acks[i] = a;
    end
  endtask

  task automatic check_outputs(input string tag, input logic [9:0] y, input logic [7:0] vy,
                               input logic [1:0] g, input logic c);
    check({tag, "_ball_y"}, 32'(ball_y), 32'(y));
    check({tag, "_ball_vy"}, 32'(ball_vy), 32'(vy));
    check({tag, "_grav"}, 32'(gravity_counter), 32'(g));
    check({tag, "_coll"}, 32'(is_collusion), 32'(c));
  endtask

  initial begin
    vec_t       v;
    logic [6:0] acks;
    logic       a;
    int         v0, e0, o0;

    vecs[0] = '{56'hAA_80_C5_07_02_01_00, 6, 7'h3F, 1, 0, 10'h2C5, 8'h07, 2'd2, 1'b1};
    vecs[1] = '{56'hAB_11_22_33_44_55_00, 6, 7'h00, 0, 0, 10'h2C5, 8'h07, 2'd2, 1'b1};
    vecs[2] = '{56'hAA_40_12_34_00_00_00, 4, 7'h0F, 0, 1, 10'h2C5, 8'h07, 2'd2, 1'b1};
    vecs[3] = '{56'hAA_C0_FF_80_03_01_99, 7, 7'h3F, 0, 1, 10'h2C5, 8'h07, 2'd2, 1'b1};
    vecs[4] = '{56'hAA_40_3C_F0_01_00_00, 6, 7'h3F, 1, 0, 10'h13C, 8'hF0, 2'd1, 1'b0};

    reset = 1'b1;
    scl   = 1'b1;
    sda_m = 1'b1;
    #30;
    reset = 1'b0;
    #40;

    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(ball_data_valid), 0);
    check("rst_err", 32'(frame_error), 0);
    check_outputs("rst", 10'h0, 8'h0, 2'd0, 1'b0);

    scl = 1'b0; #Q;

    for (int n = 0; n < 5; n++) begin
      v  = vecs[n];
      v0 = valid_cnt;
      e0 = err_cnt;
      o0 = oe_cnt;
      send_frame(v.bytes, v.nb, acks);
      for (int i = 0; i < v.nb; i++)
        check($sformatf("v%0d_ack%0d", n, i), 32'(acks[i]), 32'(v.ack[i]));
      i2c_stop();
      check($sformatf("v%0d_valid_pulses", n), 32'(valid_cnt - v0), 32'(v.e_valid));
      check($sformatf("v%0d_err_pulses", n), 32'(err_cnt - e0), 32'(v.e_err));
      check($sformatf("v%0d_busy", n), 32'(busy), 0);
      check_outputs($sformatf("v%0d", n), v.y, v.vy, v.g, v.c);
      if (v.ack == 7'h00)
        check($sformatf("v%0d_oe_cycles", n), 32'(oe_cnt - o0), 0);
      if (v.e_valid != 0)
        check($sformatf("v%0d_latency", n),
              32'((t_valid >= t_rise && t_valid - t_rise <= 40) ? 1 : 0), 1);
      scl = 1'b0; #Q;
    end

    // Two data bytes, repeated START, then a full frame carrying ball_y = 5.
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(56'hAA_01_02_00_00_00_00, 3, acks);
    check("rs_partial_acks", 32'(acks[2:0]), 32'h7);
    check("rs_busy_mid", 32'(busy), 1);
    send_frame(56'hAA_00_05_11_03_00_00, 6, acks);
    check("rs_err_pulses", 32'(err_cnt - e0), 1);
    check("rs_full_acks", 32'(acks[5:0]), 32'h3F);
    i2c_stop();
    check("rs_valid_pulses", 32'(valid_cnt - v0), 1);
    check("rs_err_total", 32'(err_cnt - e0), 1);
    check_outputs("rs", 10'h005, 8'h11, 2'd3, 1'b0);
    scl = 1'b0; #Q;

    // Reset while the slave is driving ACK for a data byte.
    i2c_start();
    send_byte(8'hAA, a);
    send_byte(8'h80, a);
    send_bits(8'hC5);
    sda_m = 1'b1; #Q;
    scl = 1'b1; #Q;
    check("mid_oe_before_reset", 32'(sda_oe), 1);
    reset = 1'b1;
    #1;
    check("mid_oe_after_reset", 32'(sda_oe), 0);
    check("mid_busy_after_reset", 32'(busy), 0);
    check_outputs("mid_reset", 10'h0, 8'h0, 2'd0, 1'b0);
    #9;
    reset = 1'b0;
    #Q;
    scl = 1'b0; #(2*Q);

    v  = vecs[0];
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(v.bytes, v.nb, acks);
    check("post_reset_acks", 32'(acks[5:0]), 32'h3F);
    i2c_stop();
    check("post_reset_valid", 32'(valid_cnt - v0), 1);
    check("post_reset_err", 32'(err_cnt - e0), 0);
    check_outputs("post_reset", v.y, v.vy, v.g, v.c);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_ball_receiver.md
Name: i2c_ball_receiver

Overview:
- Right-player I2C slave that receives the ball hand-off frame sent by the left-player I2C master.
- Samples raw SCL/SDA, detects START/STOP, matches the address byte and ACKs each byte.
- Reassembles ball_y, ball_vy, gravity_counter and is_collusion, then presents them to the right-player game logic with a one-cycle valid pulse.
- Sits between the I2C pins (open-drain SDA) and the right-player ball FSM.

Parameters:
- SLAVE_ADDR, 8'hAA, full first byte to match (7-bit address 0x55, R/W=0).
- NUM_DATA, 5, number of data bytes in one frame.
- SYNC_STAGES, 2, flip-flop stages on SCL/SDA before edge detection.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- scl  input  1  raw I2C clock from bus
- sda_in  input  1  raw I2C data from bus
- sda_oe  output  1  1 = pull SDA low (ACK); 0 = release
- ball_y  output  10  received ball y position
- ball_vy  output  8  received ball vertical velocity
- gravity_counter  output  2  received gravity phase
- is_collusion  output  1  received collision flag
- ball_data_valid  output  1  one-clk pulse when new frame values are applied
- frame_error  output  1  one-clk pulse on a malformed frame
- busy  output  1  high from an address-matched START until STOP or abort

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - sda_oe, ball_data_valid, frame_error and busy go to 0.
  - ball_y, ball_vy, gravity_counter and is_collusion go to 0.
  - Shift register and byte counter are cleared.
- Line conditioning:
  - scl and sda_in pass through SYNC_STAGES flip-flops, with previous-value registers for edge detection.
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
  - Bits are sampled on synced SCL rising edges, MSB first.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: wait for START, then go to ADDR with bit count 0.
- ADDR:
  - Shift 8 bits.
  - On the SCL fall after bit 8: if byte == SLAVE_ADDR, go to ADDR_ACK, set sda_oe=1 and busy=1; otherwise go to IGNORE with sda_oe=0 (NACK).
- ADDR_ACK / DATA_ACK:
  - Hold sda_oe=1 through the 9th SCL high phase.
  - On the next SCL fall, release sda_oe and go to DATA.
- DATA:
  - Shift 8 bits. On the SCL fall after bit 8, store the byte into staging register idx = byte count.
  - If byte count < NUM_DATA: ACK (go to DATA_ACK) and increment the count.
  - Otherwise: NACK, set an overflow flag and go to IGNORE.
- Frame mapping:
  - byte0[7:6] = ball_y[9:8]; byte0[5:0] are ignored.
  - byte1 = ball_y[7:0]; byte2 = ball_vy.
  - byte3[1:0] = gravity_counter; byte4[0] = is_collusion.
- STOP in any non-IDLE state:
  - If the address matched, byte count == NUM_DATA and there is no overflow: copy staging to outputs on the same clk and pulse ball_data_valid for 1 clk.
  - Else, if the address matched: pulse frame_error for 1 clk; outputs are unchanged.
  - In all cases: go to IDLE, clear busy, sda_oe=0, clear count.
- STOP with the address not matched (IGNORE entered from ADDR): no pulses.
- Repeated START in any state:
  - Discard staging; no valid pulse.
  - frame_error pulses if busy was 1.
  - Restart at ADDR.
- Latency: ball_data_valid asserts at most SYNC_STAGES+2 clk after the SDA rise at the pin.
- Outputs hold their values between frames; a partial frame never modifies them.
- START and STOP cannot coincide; STOP takes priority over bit sampling.
- sda_oe only ever drives low; no read transactions are supported (R/W=1 addresses mismatch).

Decomposition:
- Package i2c_ball_pkg holds:
  - SLAVE_ADDR and NUM_DATA defaults.
  - The rx_state_t enum.
  - Byte-index constants: IDX_YHI=0, IDX_YLO=1, IDX_VY=2, IDX_GRAV=3, IDX_COLL=4.
- Sub-module i2c_line_sync: synchronizers plus scl_rise, scl_fall, start_det, stop_det, sda_s.
- The top level holds the FSM, shift register, staging and outputs.

Test Plan:
- Good frame: bytes 0xAA, 0x80, 0xC5, 0x07, 0x02, 0x01, then STOP -> all 6 bytes ACKed; ball_y=0x2C5 (709), ball_vy=0x07, gravity_counter=2, is_collusion=1; ball_data_valid pulses exactly once; busy falls.
- Address 0xAB followed by 5 bytes and STOP -> every byte NACKed (sda_oe never 1); no valid or error pulse; outputs unchanged.
- 0xAA plus 3 data bytes, then STOP -> 3 ACKs; frame_error pulses once; outputs keep the prior frame values.
- 0xAA plus 2 bytes, repeated START, then a full good frame with ball_y=0x005 -> one frame_error pulse, then one valid pulse with ball_y=5.
- 0xAA plus 6 data bytes, then STOP -> 6th byte NACKed; frame_error pulses; no valid pulse.
- Reset asserted mid-data-byte while sda_oe=1 -> sda_oe=0 and all outputs 0 immediately; a subsequent good frame is received correctly.
